// File: rtl/mult16_seq_if.sv
// Handshake and operand/result bundle for the sequential 16x16 multiplier.
// The master issues requests; the slave (the multiplier) returns status and results.
interface mult16_seq_if;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [15:0] product_hi;
   logic        overflow;

   modport master (
      output start, a, b,
      input  busy, done, product, product_hi, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, product, product_hi, overflow
   );
endinterface

// File: rtl/mult16_seq.sv
// Shift-and-add unsigned 16x16 multiplier: one Adder16 pass per cycle, 16 steps,
// full 32-bit product plus an overflow flag for low-half-only consumers.
module Adder16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic carry;

   // Ripple chain kept in one procedural loop so each stage sees the previous carry.
   always_comb begin
      sum   = '0;
      carry = cin;
      for (int i = 0; i < 16; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end
endmodule

module mult16_seq (
   input  logic         clock,
   input  logic         reset_n,
   mult16_seq_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] m_q, m_d;
   logic [15:0] p_q, p_d;
   logic [15:0] q_q, q_d;
   logic        c_q, c_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] prod_lo_q, prod_lo_d;
   logic [15:0] prod_hi_q, prod_hi_d;
   logic        ovf_q, ovf_d;

   logic [15:0] add_sum;
   logic        add_cout;

   Adder16 u_add (
      .a    (p_q),
      .b    (m_q),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      p_d       = p_q;
      q_d       = q_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      prod_lo_d = prod_lo_q;
      prod_hi_d = prod_hi_q;
      ovf_d     = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               m_d     = bus.a;
               q_d     = bus.b;
               p_d     = '0;
               c_d     = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            // The adder carry lands in P[15] after the shift, so no bit is lost.
            if (q_q[0]) begin
               c_d = add_cout;
               p_d = {add_cout, add_sum[15:1]};
               q_d = {add_sum[0], q_q[15:1]};
            end else begin
               c_d = 1'b0;
               p_d = {1'b0, p_q[15:1]};
               q_d = {p_q[0], q_q[15:1]};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
               prod_lo_d = q_d;
               prod_hi_d = p_d;
               ovf_d     = |p_d;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         p_q       <= '0;
         q_q       <= '0;
         c_q       <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         prod_lo_q <= '0;
         prod_hi_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         p_q       <= p_d;
         q_q       <= q_d;
         c_q       <= c_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         prod_lo_q <= prod_lo_d;
         prod_hi_q <= prod_hi_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.product    = prod_lo_q;
   assign bus.product_hi = prod_hi_q;
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_mult16_seq.sv
// Scoreboard bench for mult16_seq: requests push a*b and the expected done cycle,
// a monitor pops and compares on every done pulse.
module tb_mult16_seq;
   logic clock = 1'b0;
   logic reset_n = 1'b0;

   mult16_seq_if bus ();

   mult16_seq dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] prod;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   busy_run = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Monitor: compares every done pulse against the oldest pending expectation.
   always @(negedge clock) begin
      if (bus.busy === 1'b1 && bus.done === 1'b1) chk("busy_and_done", 1, 0);
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("product", {16'h0, bus.product}, {16'h0, e.prod[15:0]});
            chk("product_hi", {16'h0, bus.product_hi}, {16'h0, e.prod[31:16]});
            chk("overflow", {31'h0, bus.overflow}, {31'h0, (e.prod[31:16] != 16'h0)});
            chk("done_cycle", cyc, e.cyc);
            chk("busy_cycles", busy_run, 16);
         end
         busy_run = 0;
      end else if (bus.busy === 1'b1) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   // Called on a negedge with the DUT idle: the next edge accepts, and done is
   // visible in the cycle following the 16th step edge.
   task automatic issue(input logic [15:0] ia, input logic [15:0] ib);
      exp_t e;
      bus.start = 1'b1;
      bus.a     = ia;
      bus.b     = ib;
      e.prod    = {16'h0, ia} * {16'h0, ib};
      e.cyc     = cyc + 1 + 16;
      sb.push_back(e);
      @(negedge clock);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
      chk("drain_timeout", sb.size(), 0);
      // DONE cycle is still ahead of the next IDLE edge.
      @(negedge clock);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, {31'h0, bus.busy}, 0);
      chk({tag, "_done"}, {31'h0, bus.done}, 0);
      chk({tag, "_product"}, {16'h0, bus.product}, 0);
      chk({tag, "_product_hi"}, {16'h0, bus.product_hi}, 0);
      chk({tag, "_overflow"}, {31'h0, bus.overflow}, 0);
   endtask

   initial begin
      exp_t e;
      int   c0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clock);
      chk_zero("reset");
      reset_n = 1'b1;
      @(negedge clock);

      issue(16'd3, 16'd5);
      drain();
      issue(16'hFFFF, 16'hFFFF);
      drain();
      issue(16'h0100, 16'h0100);
      drain();
      issue(16'h1234, 16'h0000);
      drain();

      // A start during RUN must be ignored and yield no second done.
      issue(16'd7, 16'd9);
      repeat (4) @(negedge clock);
      bus.start = 1'b1;
      bus.a     = 16'hAAAA;
      bus.b     = 16'h5555;
      @(negedge clock);
      bus.start = 1'b0;
      drain();
      repeat (25) @(negedge clock);

      // Reset at step 8 aborts the operation.
      issue(16'h00FF, 16'h0101);
      repeat (7) @(negedge clock);
      reset_n = 1'b0;
      sb.delete();
      @(negedge clock);
      chk_zero("abort");
      reset_n = 1'b1;
      repeat (25) @(negedge clock);
      issue(16'd2, 16'h8000);
      drain();

      // start held high: accepted every 18 cycles, never in the DONE cycle.
      bus.start = 1'b1;
      bus.a     = 16'd6;
      bus.b     = 16'd7;
      c0 = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         e.prod = 32'd42;
         e.cyc  = c0 + 16 + 18 * k;
         sb.push_back(e);
      end
      repeat (40) @(negedge clock);
      bus.start = 1'b0;
      drain();
      repeat (20) @(negedge clock);

      for (int n = 0; n < 20; n++) begin
         logic [15:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (n % 5 == 0) ra = 16'hFFFF;
         issue(ra, rb);
         drain();
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end

      repeat (25) @(negedge clock);
      chk("final_queue_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
